// File: rtl/canv_layer_mix_pkg.sv
// Shared types for the canvas layer compositor: depth codes, the per-layer
// configuration record and its reset value.
package canv_pkg;

  localparam logic [1:0] BPP_1 = 2'd0;
  localparam logic [1:0] BPP_2 = 2'd1;
  localparam logic [1:0] BPP_4 = 2'd2;
  localparam logic [1:0] BPP_8 = 2'd3;

  // Palette base is stored at a fixed width so the struct stays unparameterised;
  // the top level truncates the offset sum to the CLUT address width.
  localparam int PAL_W = 16;

  typedef struct packed {
    logic             en;
    logic [1:0]       bpp;
    logic [PAL_W-1:0] pal_base;
    logic             transp_en;
    logic [7:0]       transp_idx;
  } layer_cfg_t;

  localparam layer_cfg_t LAYER_CFG_RST = '{
    en:         1'b0,
    bpp:        BPP_4,
    pal_base:   '0,
    transp_en:  1'b0,
    transp_idx: 8'h00
  };

  function automatic logic [7:0] bpp_mask(input logic [1:0] bpp);
    case (bpp)
      BPP_1:   bpp_mask = 8'h01;
      BPP_2:   bpp_mask = 8'h03;
      BPP_4:   bpp_mask = 8'h0F;
      default: bpp_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/canv_layer_mix_if.sv
// Pixel, vram and configuration bus between the display timing front end
// and the layer compositor.
interface canv_layer_mix_if #(
  parameter int LAYERS     = 2,
  parameter int WORD       = 32,
  parameter int PIX_IDW    = 5,
  parameter int CIDX_ADDRW = 8
);
  logic                      frame_start;
  logic [LAYERS*PIX_IDW-1:0] pix_id;
  logic [LAYERS-1:0]         paint;
  logic [LAYERS*WORD-1:0]    vram_dout;
  logic                      cfg_we;
  logic [1:0]                cfg_layer;
  logic                      cfg_en;
  logic [1:0]                cfg_bpp;
  logic [CIDX_ADDRW-1:0]     cfg_pal_base;
  logic                      cfg_transp_en;
  logic [7:0]                cfg_transp_idx;
  logic                      cfg_pending;
  logic [CIDX_ADDRW-1:0]     cidx;
  logic                      cidx_valid;
  logic [LAYERS-1:0]         layer_hit;

  modport master (
    output frame_start, pix_id, paint, vram_dout,
    output cfg_we, cfg_layer, cfg_en, cfg_bpp, cfg_pal_base, cfg_transp_en, cfg_transp_idx,
    input  cfg_pending, cidx, cidx_valid, layer_hit
  );

  modport slave (
    input  frame_start, pix_id, paint, vram_dout,
    input  cfg_we, cfg_layer, cfg_en, cfg_bpp, cfg_pal_base, cfg_transp_en, cfg_transp_idx,
    output cfg_pending, cidx, cidx_valid, layer_hit
  );
endinterface

// File: rtl/canv_layer_mix_pix_extract.sv
// One layer's pixel path: aligns pix_id/paint with vram data, extracts the raw
// index at the active depth and registers it with its opacity (stage E).
module canv_pix_extract
  import canv_pkg::*;
#(
  parameter int WORD     = 32,
  parameter int PIX_IDW  = 5,
  parameter int VRAM_LAT = 2
) (
  input  logic               clk_pix,
  input  logic               rst_pix_n,
  input  logic [PIX_IDW-1:0] i_pix_id,
  input  logic               i_paint,
  input  logic [WORD-1:0]    i_vram_dout,
  input  logic               i_en,
  input  logic [1:0]         i_bpp,
  input  logic               i_transp_en,
  input  logic [7:0]         i_transp_idx,
  output logic [7:0]         o_raw,
  output logic               o_opaque
);

  logic [PIX_IDW-1:0] r_pid_dl   [VRAM_LAT];
  logic               r_paint_dl [VRAM_LAT];
  logic [7:0]         r_raw_p1;
  logic               r_opq_p1;

  logic [PIX_IDW-1:0] w_shift;
  logic [7:0]         w_raw;
  logic               w_opaque;

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      for (int i = 0; i < VRAM_LAT; i++) begin
        r_pid_dl[i]   <= '0;
        r_paint_dl[i] <= 1'b0;
      end
    end else begin
      r_pid_dl[0]   <= i_pix_id;
      r_paint_dl[0] <= i_paint;
      for (int i = 1; i < VRAM_LAT; i++) begin
        r_pid_dl[i]   <= r_pid_dl[i-1];
        r_paint_dl[i] <= r_paint_dl[i-1];
      end
    end
  end

  // Shift kept at PIX_IDW bits so it wraps modulo WORD, dropping excess pix_id MSBs.
  assign w_shift  = r_pid_dl[VRAM_LAT-1] << i_bpp;
  assign w_raw    = 8'(i_vram_dout >> w_shift) & bpp_mask(i_bpp);
  assign w_opaque = r_paint_dl[VRAM_LAT-1] & i_en & ~(i_transp_en & (w_raw == i_transp_idx));

  // ---- stage E ----
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      r_raw_p1 <= '0;
      r_opq_p1 <= 1'b0;
    end else begin
      r_raw_p1 <= w_raw;
      r_opq_p1 <= w_opaque;
    end
  end

  assign o_raw    = r_raw_p1;
  assign o_opaque = r_opq_p1;

endmodule

// File: rtl/canv_layer_mix.sv
// Multi-layer canvas compositor: double-buffered per-layer config committed at
// frame start, per-layer extraction, and priority selection into one CLUT index.
module canv_layer_mix
  import canv_pkg::*;
#(
  parameter int LAYERS     = 2,
  parameter int WORD       = 32,
  parameter int PIX_IDW    = 5,
  parameter int CIDX_ADDRW = 8,
  parameter int VRAM_LAT   = 2
) (
  input logic           clk_pix,
  input logic           rst_pix_n,
  canv_layer_mix_if.slave bus
);

  layer_cfg_t r_shadow [LAYERS];
  layer_cfg_t r_active [LAYERS];
  logic       r_pending;

  layer_cfg_t w_wr_cfg;
  logic       w_wr_ok;

  logic [7:0]            w_raw_p1 [LAYERS];
  logic [LAYERS-1:0]     w_opq_p1;
  logic [CIDX_ADDRW-1:0] w_idx    [LAYERS];

  logic [CIDX_ADDRW-1:0] w_cidx;
  logic                  w_valid;
  logic [LAYERS-1:0]     w_hit;
  logic [CIDX_ADDRW-1:0] r_cidx_p2;
  logic                  r_valid_p2;
  logic [LAYERS-1:0]     r_hit_p2;

  assign w_wr_cfg = '{
    en:         bus.cfg_en,
    bpp:        bus.cfg_bpp,
    pal_base:   PAL_W'(bus.cfg_pal_base),
    transp_en:  bus.cfg_transp_en,
    transp_idx: bus.cfg_transp_idx
  };
  assign w_wr_ok = bus.cfg_we && (int'(bus.cfg_layer) < LAYERS);

  // A write landing in the commit cycle goes straight into the active bank too.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      for (int i = 0; i < LAYERS; i++) begin
        r_shadow[i] <= LAYER_CFG_RST;
        r_active[i] <= LAYER_CFG_RST;
      end
      r_pending <= 1'b0;
    end else begin
      for (int i = 0; i < LAYERS; i++) begin
        if (w_wr_ok && int'(bus.cfg_layer) == i) r_shadow[i] <= w_wr_cfg;
        if (bus.frame_start)
          r_active[i] <= (w_wr_ok && int'(bus.cfg_layer) == i) ? w_wr_cfg : r_shadow[i];
      end
      if (bus.frame_start)  r_pending <= 1'b0;
      else if (w_wr_ok)     r_pending <= 1'b1;
    end
  end

  for (genvar g = 0; g < LAYERS; g++) begin : g_layer
    canv_pix_extract #(
      .WORD     (WORD),
      .PIX_IDW  (PIX_IDW),
      .VRAM_LAT (VRAM_LAT)
    ) u_extract (
      .clk_pix      (clk_pix),
      .rst_pix_n    (rst_pix_n),
      .i_pix_id     (bus.pix_id[g*PIX_IDW +: PIX_IDW]),
      .i_paint      (bus.paint[g]),
      .i_vram_dout  (bus.vram_dout[g*WORD +: WORD]),
      .i_en         (r_active[g].en),
      .i_bpp        (r_active[g].bpp),
      .i_transp_en  (r_active[g].transp_en),
      .i_transp_idx (r_active[g].transp_idx),
      .o_raw        (w_raw_p1[g]),
      .o_opaque     (w_opq_p1[g])
    );

    assign w_idx[g] = CIDX_ADDRW'(PAL_W'(w_raw_p1[g]) + r_active[g].pal_base);
  end

  // Walk from lowest priority up so the lowest-numbered opaque layer overwrites last.
  always_comb begin
    w_cidx  = '0;
    w_valid = 1'b0;
    w_hit   = '0;
    for (int i = LAYERS - 1; i >= 0; i--) begin
      if (w_opq_p1[i]) begin
        w_cidx   = w_idx[i];
        w_valid  = 1'b1;
        w_hit    = '0;
        w_hit[i] = 1'b1;
      end
    end
  end

  // ---- stage C ----
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      r_cidx_p2  <= '0;
      r_valid_p2 <= 1'b0;
      r_hit_p2   <= '0;
    end else begin
      r_cidx_p2  <= w_cidx;
      r_valid_p2 <= w_valid;
      r_hit_p2   <= w_hit;
    end
  end

  assign bus.cfg_pending = r_pending;
  assign bus.cidx        = r_cidx_p2;
  assign bus.cidx_valid  = r_valid_p2;
  assign bus.layer_hit   = r_hit_p2;

endmodule

// File: tb/tb_canv_layer_mix.sv
// Self-checking bench for canv_layer_mix: directed scenarios plus randomized
// pixel streams checked against an arithmetic model of layer composition.
module tb_canv_layer_mix;

  localparam int LAYERS = 2;
  localparam int WORD   = 32;
  localparam int PIDW   = 5;
  localparam int CIDXW  = 8;
  localparam int LAT    = 2;
  localparam int MAXPIX = 64;
  localparam int MAXCYC = 80;

  logic clk_pix   = 1'b0;
  logic rst_pix_n = 1'b0;
  always #5 clk_pix = ~clk_pix;

  canv_layer_mix_if #(.LAYERS(LAYERS), .WORD(WORD), .PIX_IDW(PIDW), .CIDX_ADDRW(CIDXW)) bus ();

  canv_layer_mix #(
    .LAYERS(LAYERS), .WORD(WORD), .PIX_IDW(PIDW), .CIDX_ADDRW(CIDXW), .VRAM_LAT(LAT)
  ) dut (
    .clk_pix   (clk_pix),
    .rst_pix_n (rst_pix_n),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit en;
    int bpp;
    int pal;
    bit te;
    int ti;
  } mcfg_t;

  mcfg_t m_sh [LAYERS];
  mcfg_t m_ac [LAYERS];
  bit    m_pend;

  logic [PIDW-1:0]   s_pid   [MAXPIX][LAYERS];
  logic              s_paint [MAXPIX][LAYERS];
  logic [WORD-1:0]   s_word  [MAXPIX][LAYERS];
  logic [CIDXW-1:0]  g_cidx  [MAXCYC];
  logic              g_valid [MAXCYC];
  logic [LAYERS-1:0] g_hit   [MAXCYC];

  initial begin
    #2000000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int l = 0; l < LAYERS; l++) begin
      m_sh[l] = '{en: 1'b0, bpp: 2, pal: 0, te: 1'b0, ti: 0};
      m_ac[l] = m_sh[l];
    end
    m_pend = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.frame_start    = 1'b0;
    bus.pix_id         = '0;
    bus.paint          = '0;
    bus.vram_dout      = '0;
    bus.cfg_we         = 1'b0;
    bus.cfg_layer      = '0;
    bus.cfg_en         = 1'b0;
    bus.cfg_bpp        = '0;
    bus.cfg_pal_base   = '0;
    bus.cfg_transp_en  = 1'b0;
    bus.cfg_transp_idx = '0;
  endtask

  task automatic clear_stim();
    for (int k = 0; k < MAXPIX; k++)
      for (int l = 0; l < LAYERS; l++) begin
        s_pid[k][l]   = '0;
        s_paint[k][l] = 1'b0;
        s_word[k][l]  = '0;
      end
  endtask

  task automatic rand_stim(input int n, input bit all_paint);
    for (int k = 0; k < n; k++)
      for (int l = 0; l < LAYERS; l++) begin
        s_pid[k][l]   = PIDW'($urandom);
        s_paint[k][l] = all_paint ? 1'b1 : 1'($urandom_range(0, 3) != 0);
        s_word[k][l]  = $urandom;
      end
  endtask

  task automatic cfg_write(input int layer, input bit en, input int bpp, input int pal,
                           input bit te, input int ti, input bit fs);
    bus.cfg_we         = 1'b1;
    bus.cfg_layer      = 2'(layer);
    bus.cfg_en         = en;
    bus.cfg_bpp        = 2'(bpp);
    bus.cfg_pal_base   = CIDXW'(pal);
    bus.cfg_transp_en  = te;
    bus.cfg_transp_idx = 8'(ti);
    bus.frame_start    = fs;
    @(posedge clk_pix); #1;
    bus.cfg_we      = 1'b0;
    bus.frame_start = 1'b0;
    if (layer < LAYERS) m_sh[layer] = '{en: en, bpp: bpp, pal: pal, te: te, ti: ti};
    if (fs) begin
      for (int l = 0; l < LAYERS; l++) m_ac[l] = m_sh[l];
      m_pend = 1'b0;
    end else if (layer < LAYERS) begin
      m_pend = 1'b1;
    end
  endtask

  task automatic commit();
    bus.frame_start = 1'b1;
    @(posedge clk_pix); #1;
    bus.frame_start = 1'b0;
    for (int l = 0; l < LAYERS; l++) m_ac[l] = m_sh[l];
    m_pend = 1'b0;
  endtask

  // Pixel k is presented in cycle k; its vram word arrives LAT cycles later.
  // g_*[c] holds the outputs just after clock edge c, so pixel k lands at index k+LAT+1.
  task automatic run_stream(input int n);
    logic [LAYERS*PIDW-1:0] pv;
    logic [LAYERS-1:0]      pp;
    logic [LAYERS*WORD-1:0] wv;
    for (int c = 0; c < n + LAT + 3; c++) begin
      for (int l = 0; l < LAYERS; l++) begin
        pv[l*PIDW +: PIDW] = (c < n) ? s_pid[c][l] : '0;
        pp[l]              = (c < n) ? s_paint[c][l] : 1'b0;
        wv[l*WORD +: WORD] = (c >= LAT && c - LAT < n) ? s_word[c-LAT][l] : '0;
      end
      bus.pix_id    = pv;
      bus.paint     = pp;
      bus.vram_dout = wv;
      @(posedge clk_pix); #1;
      g_cidx[c]  = bus.cidx;
      g_valid[c] = bus.cidx_valid;
      g_hit[c]   = bus.layer_hit;
    end
    bus.pix_id    = '0;
    bus.paint     = '0;
    bus.vram_dout = '0;
  endtask

  function automatic void model_pixel(input int k, output bit v, output int hit, output int cidx);
    v = 1'b0; hit = 0; cidx = 0;
    for (int l = 0; l < LAYERS; l++) begin
      int n, sh, raw;
      bit opq;
      n   = 1 << m_ac[l].bpp;
      sh  = (int'(s_pid[k][l]) * n) % WORD;
      raw = int'(s_word[k][l] >> sh) & ((1 << n) - 1);
      opq = s_paint[k][l] && m_ac[l].en && !(m_ac[l].te && raw == m_ac[l].ti);
      if (opq && !v) begin
        v    = 1'b1;
        hit  = 1 << l;
        cidx = (raw + m_ac[l].pal) % (1 << CIDXW);
      end
    end
  endfunction

  task automatic test_reset();
    idle_inputs();
    model_reset();
    rst_pix_n = 1'b0;
    bus.paint     = '1;
    bus.vram_dout = '1;
    repeat (3) @(posedge clk_pix);
    #1;
    checks++; if (bus.cidx !== '0) begin errors++; $display("FAIL reset_cidx got %h want 0", bus.cidx); end
    checks++; if (bus.cidx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.cidx_valid); end
    checks++; if (bus.layer_hit !== '0) begin errors++; $display("FAIL reset_hit got %b want 0", bus.layer_hit); end
    checks++; if (bus.cfg_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b want 0", bus.cfg_pending); end
    rst_pix_n = 1'b1;
    clear_stim();
    rand_stim(16, 1'b1);
    run_stream(16);
    for (int c = 0; c < 16 + LAT + 3; c++) begin
      checks++;
      if (g_valid[c] !== 1'b0) begin errors++; $display("FAIL post_reset_valid cycle %0d got %b want 0", c, g_valid[c]); end
    end
  endtask

  task automatic test_extract_4bpp();
    cfg_write(0, 1'b1, 2, 0, 1'b0, 0, 1'b0);
    commit();
    clear_stim();
    s_pid[0][0] = 5'd5; s_paint[0][0] = 1'b1; s_word[0][0] = 32'h87654321;
    run_stream(1);
    checks++; if (g_valid[LAT] !== 1'b0) begin errors++; $display("FAIL x4_early got %b want 0", g_valid[LAT]); end
    checks++; if (g_cidx[LAT+1] !== 8'h06) begin errors++; $display("FAIL x4_cidx got %h want 06", g_cidx[LAT+1]); end
    checks++; if (g_valid[LAT+1] !== 1'b1) begin errors++; $display("FAIL x4_valid got %b want 1", g_valid[LAT+1]); end
    checks++; if (g_hit[LAT+1] !== 2'b01) begin errors++; $display("FAIL x4_hit got %b want 01", g_hit[LAT+1]); end
    checks++; if (g_valid[LAT+2] !== 1'b0) begin errors++; $display("FAIL x4_late got %b want 0", g_valid[LAT+2]); end
  endtask

  task automatic test_priority_transp();
    cfg_write(0, 1'b1, 2, 0, 1'b1, 0, 1'b0);
    cfg_write(1, 1'b1, 2, 8'h40, 1'b0, 0, 1'b0);
    commit();
    clear_stim();
    s_pid[0][0] = 5'd0; s_paint[0][0] = 1'b1; s_word[0][0] = 32'h0000_0000;
    s_pid[0][1] = 5'd1; s_paint[0][1] = 1'b1; s_word[0][1] = 32'h0000_0050;
    s_pid[1][0] = 5'd0; s_paint[1][0] = 1'b1; s_word[1][0] = 32'h0000_0003;
    s_pid[1][1] = 5'd1; s_paint[1][1] = 1'b1; s_word[1][1] = 32'h0000_0050;
    run_stream(2);
    checks++; if (g_hit[LAT+1] !== 2'b10) begin errors++; $display("FAIL transp_hit got %b want 10", g_hit[LAT+1]); end
    checks++; if (g_cidx[LAT+1] !== 8'h45) begin errors++; $display("FAIL transp_cidx got %h want 45", g_cidx[LAT+1]); end
    checks++; if (g_hit[LAT+2] !== 2'b01) begin errors++; $display("FAIL prio_hit got %b want 01", g_hit[LAT+2]); end
    checks++; if (g_cidx[LAT+2] !== 8'h03) begin errors++; $display("FAIL prio_cidx got %h want 03", g_cidx[LAT+2]); end
  endtask

  task automatic test_palette_wrap();
    cfg_write(0, 1'b1, 3, 8'hF0, 1'b0, 0, 1'b0);
    commit();
    clear_stim();
    s_pid[0][0] = 5'd1; s_paint[0][0] = 1'b1; s_word[0][0] = 32'h0000_2000;
    run_stream(1);
    checks++; if (g_cidx[LAT+1] !== 8'h10) begin errors++; $display("FAIL wrap8_cidx got %h want 10", g_cidx[LAT+1]); end
    checks++; if (g_hit[LAT+1] !== 2'b01) begin errors++; $display("FAIL wrap8_hit got %b want 01", g_hit[LAT+1]); end
    cfg_write(0, 1'b1, 0, 8'hFF, 1'b0, 0, 1'b0);
    commit();
    clear_stim();
    s_pid[0][0] = 5'd7; s_paint[0][0] = 1'b1; s_word[0][0] = 32'h0000_0080;
    run_stream(1);
    checks++; if (g_cidx[LAT+1] !== 8'h00) begin errors++; $display("FAIL wrap1_cidx got %h want 00", g_cidx[LAT+1]); end
    checks++; if (g_valid[LAT+1] !== 1'b1) begin errors++; $display("FAIL wrap1_valid got %b want 1", g_valid[LAT+1]); end
  endtask

  task automatic test_shadow_commit();
    cfg_write(0, 1'b1, 2, 0, 1'b0, 0, 1'b0);
    commit();
    cfg_write(0, 1'b1, 3, 0, 1'b0, 0, 1'b0);
    checks++; if (bus.cfg_pending !== 1'b1) begin errors++; $display("FAIL shadow_pending got %b want 1", bus.cfg_pending); end
    clear_stim();
    s_pid[0][0] = 5'd1; s_paint[0][0] = 1'b1; s_word[0][0] = 32'h0000_3412;
    run_stream(1);
    checks++; if (g_cidx[LAT+1] !== 8'h01) begin errors++; $display("FAIL shadow_old_cidx got %h want 01", g_cidx[LAT+1]); end
    commit();
    checks++; if (bus.cfg_pending !== 1'b0) begin errors++; $display("FAIL commit_pending got %b want 0", bus.cfg_pending); end
    run_stream(1);
    checks++; if (g_cidx[LAT+1] !== 8'h34) begin errors++; $display("FAIL commit_new_cidx got %h want 34", g_cidx[LAT+1]); end
    cfg_write(0, 1'b1, 2, 0, 1'b0, 0, 1'b1);
    checks++; if (bus.cfg_pending !== 1'b0) begin errors++; $display("FAIL coincident_pending got %b want 0", bus.cfg_pending); end
    run_stream(1);
    checks++; if (g_cidx[LAT+1] !== 8'h01) begin errors++; $display("FAIL coincident_cidx got %h want 01", g_cidx[LAT+1]); end
    checks++; if (bus.cfg_pending !== 1'b0) begin errors++; $display("FAIL coincident_pending_later got %b want 0", bus.cfg_pending); end
  endtask

  task automatic test_invalid_target();
    cfg_write(3, 1'b0, 0, 8'h11, 1'b1, 5, 1'b0);
    checks++; if (bus.cfg_pending !== 1'b0) begin errors++; $display("FAIL invalid_pending got %b want 0", bus.cfg_pending); end
    commit();
    clear_stim();
    s_pid[0][1] = 5'd1; s_paint[0][1] = 1'b1; s_word[0][1] = 32'h0000_0070;
    s_pid[1][0] = 5'd1; s_paint[1][0] = 1'b1; s_word[1][0] = 32'h0000_0090;
    run_stream(2);
    checks++; if (g_hit[LAT+1] !== 2'b10 || g_cidx[LAT+1] !== 8'h47) begin
      errors++; $display("FAIL invalid_l1 got hit %b cidx %h want 10 47", g_hit[LAT+1], g_cidx[LAT+1]); end
    checks++; if (g_hit[LAT+2] !== 2'b01 || g_cidx[LAT+2] !== 8'h09) begin
      errors++; $display("FAIL invalid_l0 got hit %b cidx %h want 01 09", g_hit[LAT+2], g_cidx[LAT+2]); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      for (int l = 0; l < LAYERS; l++)
        cfg_write(l, 1'($urandom_range(0, 4) != 0), $urandom_range(0, 3), $urandom_range(0, 255),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
      if (r % 2 == 0) commit();
      else cfg_write(0, 1'b1, $urandom_range(0, 3), $urandom_range(0, 255), 1'b1, $urandom_range(0, 1), 1'b1);
      clear_stim();
      rand_stim(48, 1'b0);
      run_stream(48);
      for (int k = 0; k < 48; k++) begin
        bit ev;
        int eh, ec;
        model_pixel(k, ev, eh, ec);
        checks++;
        if (g_valid[k+LAT+1] !== ev || g_hit[k+LAT+1] !== LAYERS'(eh) || g_cidx[k+LAT+1] !== CIDXW'(ec)) begin
          errors++;
          $display("FAIL rand r%0d px%0d got v%b h%b c%h want v%b h%b c%h", r, k,
                   g_valid[k+LAT+1], g_hit[k+LAT+1], g_cidx[k+LAT+1], ev, LAYERS'(eh), CIDXW'(ec));
        end
      end
    end
  endtask

  task automatic test_midreset();
    cfg_write(0, 1'b1, 2, 0, 1'b0, 0, 1'b0);
    cfg_write(1, 1'b0, 2, 0, 1'b0, 0, 1'b0);
    commit();
    bus.pix_id    = '0;
    bus.paint     = 2'b01;
    bus.vram_dout = {32'h0, 32'h0000_0005};
    repeat (5) @(posedge clk_pix);
    #1;
    checks++; if (bus.cidx_valid !== 1'b1 || bus.cidx !== 8'h05) begin
      errors++; $display("FAIL midrst_pre got v%b c%h want v1 c05", bus.cidx_valid, bus.cidx); end
    cfg_write(1, 1'b1, 1, 8'h22, 1'b0, 0, 1'b0);
    checks++; if (bus.cfg_pending !== 1'b1) begin errors++; $display("FAIL midrst_pend_pre got %b want 1", bus.cfg_pending); end
    #3 rst_pix_n = 1'b0;
    #1;
    checks++; if (bus.cidx !== '0) begin errors++; $display("FAIL midrst_cidx got %h want 0", bus.cidx); end
    checks++; if (bus.cidx_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", bus.cidx_valid); end
    checks++; if (bus.layer_hit !== '0) begin errors++; $display("FAIL midrst_hit got %b want 0", bus.layer_hit); end
    checks++; if (bus.cfg_pending !== 1'b0) begin errors++; $display("FAIL midrst_pend got %b want 0", bus.cfg_pending); end
    @(negedge clk_pix);
    rst_pix_n = 1'b1;
    @(posedge clk_pix); #1;
    model_reset();
    commit();
    clear_stim();
    rand_stim(16, 1'b1);
    run_stream(16);
    for (int c = 0; c < 16 + LAT + 3; c++) begin
      checks++;
      if (g_valid[c] !== 1'b0) begin errors++; $display("FAIL midrst_after_valid cycle %0d got %b want 0", c, g_valid[c]); end
    end
  endtask

  initial begin
    test_reset();
    test_extract_4bpp();
    test_priority_transp();
    test_palette_wrap();
    test_shadow_commit();
    test_invalid_target();
    test_random();
    test_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/canv_layer_mix.md
# canv_layer_mix

Multi-layer canvas pixel compositor for the display path, sitting between the per-layer vram display ports and the CLUT read port in the pixel clock domain. Successor to the single-layer, fixed-colour-depth pixel select:
- colour depth, palette offset and transparency are runtime registers per layer;
- configuration is double-buffered and committed at frame start;
- up to `LAYERS` canvases are priority-composited into one colour index.

## Interface
Parameters:
- `LAYERS`, 2: number of canvas layers (1–4); layer 0 has highest priority.
- `WORD`, 32: vram word width (bits).
- `PIX_IDW`, 5: pixel ID width, `$clog2(WORD)`.
- `CIDX_ADDRW`, 8: colour index width (CLUT address).
- `VRAM_LAT`, 2: cycles from address/pix_id issue to `vram_dout` valid.

Ports:
- `clk_pix` in 1: pixel clock. Single clock domain.
- `rst_pix_n` in 1: reset, asynchronous, active-low.
- `frame_start` in 1: one-cycle pulse; commit point for shadow config.
- `pix_id` in `LAYERS*PIX_IDW`: per-layer pixel ID within word, aligned with vram address issue.
- `paint` in `LAYERS`: per-layer canvas-window flag, aligned with `pix_id`.
- `vram_dout` in `LAYERS*WORD`: per-layer vram data, valid `VRAM_LAT` cycles after `pix_id`.
- `cfg_we` in 1: write the shadow config of layer `cfg_layer`.
- `cfg_layer` in 2: target layer; writes with `cfg_layer >= LAYERS` are ignored.
- `cfg_en` in 1: layer enable.
- `cfg_bpp` in 2: depth code, 0=1, 1=2, 2=4, 3=8 bpp.
- `cfg_pal_base` in `CIDX_ADDRW`: palette offset.
- `cfg_transp_en` in 1: transparency enable.
- `cfg_transp_idx` in 8: transparent raw index.
- `cfg_pending` out 1: a shadow write is awaiting commit.
- `cidx` out `CIDX_ADDRW`: composited colour index to the CLUT.
- `cidx_valid` out 1: some layer is opaque at this pixel.
- `layer_hit` out `LAYERS`: one-hot winning layer; all zero if none.

## Operation
- **Register banks.** Each layer has a shadow bank (written by `cfg_we`) and an active bank (used by the datapath).
- **Commit.** On `frame_start`, all active banks load from shadow and `cfg_pending` clears.
- **Simultaneous events.** If `cfg_we` and `frame_start` occur in the same cycle, the same-cycle write is included in the commit, and `cfg_pending` stays 0.
- **`cfg_pending`.** Set by any accepted `cfg_we` that is not simultaneous with `frame_start`.
- **Extraction, per layer.** With `n` = bpp from the active code: raw = (`vram_dout` >> (`pix_id_d` × n)) & (2^n−1), zero-extended to 8 bits. `pix_id_d` is `pix_id` delayed `VRAM_LAT` cycles.
  - The `pix_id` MSBs beyond 32/n words are ignored, i.e. the shift is taken mod `WORD`.
- **Opacity.** A layer is opaque when: `paint_d` AND active `en` AND NOT (`transp_en` AND raw == `transp_idx`).
- **Palette offset.** Layer index = raw + `pal_base`, truncated to `CIDX_ADDRW` (wraps modulo 2^`CIDX_ADDRW`).
- **Composition.** The lowest-numbered opaque layer wins and drives `cidx`, `cidx_valid`=1 and its `layer_hit` bit.
  - If no layer is opaque: `cidx`=0, `cidx_valid`=0, `layer_hit`=0.

## Timing
- **Pipeline.**
  - `pix_id`/`paint` pass through a `VRAM_LAT`-deep delay line.
  - Stage E registers raw index and opacity per layer.
  - Stage C registers the composite.
  - Latency from `pix_id` in to `cidx` out: `VRAM_LAT`+2 cycles. Fully pipelined, one pixel per cycle, no stalls.
- **Config visibility.** The active config is read at stage E. A commit on cycle t affects stage E from cycle t+1.
  - The caller issues `frame_start` in blanking, so no in-flight pixel straddles a commit.
- **Reset.** While `rst_pix_n`=0, asynchronously:
  - All outputs are 0.
  - All delay lines and pipeline registers are 0.
  - Shadow and active banks: `en`=0, `bpp`=2 (4 bpp), `pal_base`=0, `transp_en`=0, `transp_idx`=0.
- **Reset release and mid-frame reset.** After release, outputs are invalid (0) until `VRAM_LAT`+2 cycles of input have flowed. Reset mid-frame discards all in-flight pixels and pending writes.

## Structure
- **Package `canv_pkg`.**
  - bpp code constants `BPP_1`, `BPP_2`, `BPP_4`, `BPP_8`.
  - `layer_cfg_t` struct: `en`, `bpp`, `pal_base`, `transp_en`, `transp_idx`.
  - Reset default `LAYER_CFG_RST`.
- **Sub-module `canv_pix_extract`.**
  - Contents: pix_id/paint delay line, shift-mask extract, stage E register.
  - Instantiated once per layer by generate loop.
- **Top level.** Config banks, commit logic and priority compositor.

## Test plan
- **Reset defaults.** Hold `rst_pix_n`=0 mid-stream → all outputs 0 immediately. After release with no config written (`en`=0): `cidx_valid`=0 throughout.
- **4 bpp extract.** Layer 0: `en`=1, 4 bpp, `pal_base`=0, committed. `vram_dout`=0x87654321, `pix_id`=5 → `cidx`=0x06, `cidx_valid`=1, `layer_hit`=01, exactly 4 cycles after `pix_id`.
- **Priority and transparency.** Layer 0 with `transp_en`=1, `transp_idx`=0; layer 1 opaque.
  - Layer-0 raw=0 → `layer_hit`=10, `cidx` = layer-1 value.
  - Layer-0 raw=3 → `layer_hit`=01.
- **Palette wrap, 8 bpp.** `pal_base`=0xF0, raw=0x20 → `cidx`=0x10. At 1 bpp: `pal_base`=0xFF, raw=1 → `cidx`=0x00.
- **Shadow commit.**
  - Write layer 0 `bpp`=3 mid-frame → `cfg_pending`=1 and output still decoded at 4 bpp.
  - After `frame_start` → `cfg_pending`=0 and 8 bpp decode.
  - `cfg_we` coincident with `frame_start` → applied at that commit, `cfg_pending` never set.
- **Invalid target.** `LAYERS`=2, `cfg_we` with `cfg_layer`=3 → no bank changes, `cfg_pending` unchanged.
